// File: rtl/mouse_bus_peripheral_pkg.sv
// Shared definitions for the PS/2 mouse bus peripheral: register map, PS/2 frame
// states, default screen size and the position clamp helper.
package mouse_bus_peripheral_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_X      = 2'd1;
  localparam logic [1:0] REG_Y      = 2'd2;

  localparam int DEF_MAX_X = 159;
  localparam int DEF_MAX_Y = 119;

  localparam logic [7:0] STATUS_RESET = 8'h08;

  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_t;

  // Saturate a signed 10-bit candidate position into 0..hi.
  function automatic logic [7:0] clamp_pos(input logic signed [9:0] v,
                                           input logic signed [9:0] hi);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > hi)
      return hi[7:0];
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/mouse_bus_peripheral_if.sv
// CPU-side bus of the mouse peripheral. The slave supplies read data and an output
// enable; the interface turns them into the tri-stated shared BUS_DATA lines.
interface mouse_bus_peripheral_if;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OE;
  wire  [7:0] BUS_DATA;

  assign BUS_DATA = BUS_DATA_OE ? BUS_DATA_OUT : 8'bz;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE,
    input  BUS_DATA
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE,
    output BUS_DATA_OUT,
    output BUS_DATA_OE
  );

endinterface

// File: rtl/mouse_bus_peripheral_ps2_rx_byte.sv
// PS/2 byte receiver: synchronisers, falling-edge detect, frame FSM, stop/parity
// check and inactivity timeout. Parity is enforced only when MOUSE_PARITY_CHECK_EN is defined.
module ps2_rx_byte
  import mouse_bus_peripheral_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_pkt_busy,
  output logic       o_byte_valid,
  output logic       o_byte_error,
  output logic       o_timeout,
  output logic [7:0] o_byte_data
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic            r_clk_s1;
  logic            r_clk_s2;
  logic            r_clk_prev;
  logic            r_dat_s1;
  logic            r_dat_s2;
  ps2_state_t      r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [TO_W-1:0] r_to_cnt;
`ifdef MOUSE_PARITY_CHECK_EN
  logic            r_parity;
`endif

  logic w_fall;
  logic w_busy;
  logic w_frame_ok;

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_busy = (r_state != PS2_IDLE) || i_pkt_busy;

`ifdef MOUSE_PARITY_CHECK_EN
  assign w_frame_ok = r_dat_s2 & (^{r_shift, r_parity});
`else
  assign w_frame_ok = r_dat_s2;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_clk_prev   <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_state      <= PS2_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_to_cnt     <= '0;
      o_byte_valid <= 1'b0;
      o_byte_error <= 1'b0;
      o_timeout    <= 1'b0;
      o_byte_data  <= 8'd0;
`ifdef MOUSE_PARITY_CHECK_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_clk_s1     <= i_ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_clk_prev   <= r_clk_s2;
      r_dat_s1     <= i_ps2_data;
      r_dat_s2     <= r_dat_s1;
      o_byte_valid <= 1'b0;
      o_byte_error <= 1'b0;
      o_timeout    <= 1'b0;

      // Inactivity watchdog only runs while a frame or packet is in flight.
      if (w_fall || !w_busy) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
        r_to_cnt  <= '0;
        r_state   <= PS2_IDLE;
        o_timeout <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_fall) begin
        case (r_state)
          PS2_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= PS2_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          PS2_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7)
              r_state <= PS2_PARITY;
          end
          PS2_PARITY: begin
`ifdef MOUSE_PARITY_CHECK_EN
            r_parity <= r_dat_s2;
`endif
            r_state  <= PS2_STOP;
          end
          PS2_STOP: begin
            r_state <= PS2_IDLE;
            if (w_frame_ok) begin
              o_byte_valid <= 1'b1;
              o_byte_data  <= r_shift;
            end else begin
              o_byte_error <= 1'b1;
            end
          end
          default: r_state <= PS2_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/mouse_bus_peripheral.sv
// PS/2 mouse bus peripheral: assembles 3-byte packets, tracks a clamped cursor, serves
// STATUS/X/Y reads and raises IRQ 0 per packet. Build option: MOUSE_PARITY_CHECK_EN.
module mouse_bus_peripheral
  import mouse_bus_peripheral_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR      = 8'hA0,
  parameter int         MAX_X          = DEF_MAX_X,
  parameter int         MAX_Y          = DEF_MAX_Y,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PS2_CLK,
  input  logic                  PS2_DATA,
  mouse_bus_peripheral_if.slave bus
);

  localparam logic signed [9:0] MAX_X_S = 10'(MAX_X);
  localparam logic signed [9:0] MAX_Y_S = 10'(MAX_Y);

  logic [1:0] r_idx;
  logic [7:0] r_b0;
  logic [7:0] r_b1;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [7:0] r_status;
  logic       r_irq;
  logic [7:0] r_rd_data;
  logic       r_rd_oe;

  logic              w_byte_valid;
  logic              w_byte_error;
  logic              w_timeout;
  logic [7:0]        w_byte_data;
  logic              w_commit;
  logic signed [9:0] w_dx;
  logic signed [9:0] w_dy;
  logic signed [9:0] w_x_next;
  logic signed [9:0] w_y_next;
  logic [7:0]        w_offset;
  logic              w_hit;
  logic [7:0]        w_rd_mux;

  ps2_rx_byte #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .i_clk        (CLK),
    .i_rst_n      (RESET),
    .i_ps2_clk    (PS2_CLK),
    .i_ps2_data   (PS2_DATA),
    .i_pkt_busy   (r_idx != 2'd0),
    .o_byte_valid (w_byte_valid),
    .o_byte_error (w_byte_error),
    .o_timeout    (w_timeout),
    .o_byte_data  (w_byte_data)
  );

  // Deltas are 9-bit two's complement; the sign lives in byte 0.
  assign w_dx     = {r_b0[4], r_b0[4], r_b1};
  assign w_dy     = {r_b0[5], r_b0[5], w_byte_data};
  assign w_x_next = $signed({2'b00, r_x}) + w_dx;
  assign w_y_next = $signed({2'b00, r_y}) - w_dy;
  assign w_commit = w_byte_valid && (r_idx == 2'd2);

  assign w_offset = bus.BUS_ADDR - BASE_ADDR;
  assign w_hit    = (w_offset < 8'd3) && !bus.BUS_WE;

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_offset[1:0])
      REG_STATUS: w_rd_mux = r_status;
      REG_X:      w_rd_mux = r_x;
      REG_Y:      w_rd_mux = r_y;
      default:    w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_idx     <= 2'd0;
      r_b0      <= 8'd0;
      r_b1      <= 8'd0;
      r_x       <= 8'(MAX_X / 2);
      r_y       <= 8'(MAX_Y / 2);
      r_status  <= STATUS_RESET;
      r_irq     <= 1'b0;
      r_rd_data <= 8'd0;
      r_rd_oe   <= 1'b0;
    end else begin
      r_rd_oe   <= w_hit;
      r_rd_data <= w_rd_mux;

      if (w_byte_error || w_timeout) begin
        r_idx <= 2'd0;
      end else if (w_byte_valid) begin
        case (r_idx)
          2'd0: begin
            // Bit 3 is always set in a genuine first byte; anything else means we are out of step.
            if (w_byte_data[3]) begin
              r_b0  <= w_byte_data;
              r_idx <= 2'd1;
            end
          end
          2'd1: begin
            r_b1  <= w_byte_data;
            r_idx <= 2'd2;
          end
          default: begin
            r_idx    <= 2'd0;
            r_status <= r_b0 | 8'h08;
            if (!r_b0[6])
              r_x <= clamp_pos(w_x_next, MAX_X_S);
            if (!r_b0[7])
              r_y <= clamp_pos(w_y_next, MAX_Y_S);
          end
        endcase
      end

      if (w_commit)
        r_irq <= 1'b1;
      else if (bus.BUS_INTERRUPT_ACK)
        r_irq <= 1'b0;
    end
  end

  assign bus.BUS_INTERRUPT_RAISE = r_irq;
  assign bus.BUS_DATA_OUT        = r_rd_data;
  assign bus.BUS_DATA_OE         = r_rd_oe;

endmodule

// File: tb/tb_mouse_bus_peripheral.sv
// Scoreboard bench for mouse_bus_peripheral: a reference cursor model queues the
// expected STATUS/X/Y for each packet; entries are checked when the IRQ fires.
module tb_mouse_bus_peripheral;

  localparam logic [7:0] BASE = 8'hA0;
  localparam int         TO   = 400;

  logic CLK = 1'b0;
  logic RESET;
  logic PS2_CLK;
  logic PS2_DATA;

  mouse_bus_peripheral_if bus ();

  mouse_bus_peripheral #(
    .BASE_ADDR      (BASE),
    .MAX_X          (159),
    .MAX_Y          (119),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and IRQ rising-edge monitor, sampled 1 time unit after each edge.
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  logic prev_irq = 1'b0;

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (bus.BUS_INTERRUPT_RAISE === 1'b1 && prev_irq !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_irq = bus.BUS_INTERRUPT_RAISE;
  end

  // Reference cursor model and scoreboard of {STATUS, X, Y}.
  int          mx = 79;
  int          my = 59;
  logic [23:0] sb_q[$];

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_commit(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx;
    int dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (!b0[6]) mx = clampi(mx + dx, 159);
    if (!b0[7]) my = clampi(my - dy, 119);
    sb_q.push_back({b0 | 8'h08, 8'(mx), 8'(my)});
  endtask

  task automatic ps2_bit(input logic b, input bit mark_fall, input bit ack_same);
    @(negedge CLK);
    PS2_DATA = b;
    repeat (3) @(negedge CLK);
    PS2_CLK = 1'b0;
    if (mark_fall) fall_cyc = cyc;
    if (ack_same) begin
      repeat (3) @(posedge CLK);
      #1 bus.BUS_INTERRUPT_ACK = 1'b1;
      @(posedge CLK);
      #1 bus.BUS_INTERRUPT_ACK = 1'b0;
    end
    repeat (8) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic ps2_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                          input bit last, input bit ack_same);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, 1'b0);
    ps2_bit(par, 1'b0, 1'b0);
    ps2_bit(~bad_stop, last, last && ack_same);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input bit ack_same);
    ps2_byte(b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ps2_byte(b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ps2_byte(b2, 1'b0, 1'b0, 1'b1, ack_same);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge CLK);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b0;
    @(posedge CLK);
    #2;
    oe = bus.BUS_DATA_OE;
    d  = bus.BUS_DATA;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic ack_irq(input string tag);
    @(negedge CLK);
    bus.BUS_INTERRUPT_ACK = 1'b1;
    @(negedge CLK);
    bus.BUS_INTERRUPT_ACK = 1'b0;
    @(posedge CLK);
    #2;
    check_eq({tag, "_irq_clr"}, 32'(bus.BUS_INTERRUPT_RAISE), 32'd0);
  endtask

  // Pops the oldest expectation once the DUT signals a commit and compares the registers.
  task automatic check_commit(input string tag, input int base, input bit expect_rise);
    logic [23:0] exp;
    logic [7:0]  d;
    logic        oe;
    if (expect_rise) begin
      for (int i = 0; i < 200 && rise_cnt == base; i++) @(posedge CLK);
      #2;
      check_eq({tag, "_rises"}, 32'(rise_cnt), 32'(base + 1));
      check_eq({tag, "_irq_lat"}, 32'(rise_cyc - fall_cyc), 32'd4);
    end else begin
      check_eq({tag, "_irq_held"}, 32'(bus.BUS_INTERRUPT_RAISE), 32'd1);
      check_eq({tag, "_rises"}, 32'(rise_cnt), 32'(base));
    end
    check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      bus_read(BASE + 8'd0, d, oe);
      check_eq({tag, "_status"}, 32'({oe, d}), 32'({1'b1, exp[23:16]}));
      bus_read(BASE + 8'd1, d, oe);
      check_eq({tag, "_x"}, 32'({oe, d}), 32'({1'b1, exp[15:8]}));
      bus_read(BASE + 8'd2, d, oe);
      check_eq({tag, "_y"}, 32'({oe, d}), 32'({1'b1, exp[7:0]}));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       oe;
    int         base;

    RESET                 = 1'b0;
    PS2_CLK               = 1'b1;
    PS2_DATA              = 1'b1;
    bus.BUS_ADDR          = 8'h00;
    bus.BUS_WE            = 1'b0;
    bus.BUS_INTERRUPT_ACK = 1'b0;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Reset state and read timing
    check_eq("rst_irq", 32'(bus.BUS_INTERRUPT_RAISE), 32'd0);
    check_eq("rst_oe", 32'(bus.BUS_DATA_OE), 32'd0);
    bus_read(BASE + 8'd0, d, oe);
    check_eq("rst_status", 32'({oe, d}), 32'h108);
    @(posedge CLK);
    #2;
    check_eq("rd_one_cycle_oe", 32'(bus.BUS_DATA_OE), 32'd0);
    bus_read(BASE + 8'd1, d, oe);
    check_eq("rst_x", 32'({oe, d}), 32'h100 | 32'd79);
    bus_read(BASE + 8'd2, d, oe);
    check_eq("rst_y", 32'({oe, d}), 32'h100 | 32'd59);
    bus_read(8'hA3, d, oe);
    check_eq("unmapped_oe", 32'(oe), 32'd0);
    @(negedge CLK);
    bus.BUS_ADDR = BASE + 8'd1;
    bus.BUS_WE   = 1'b1;
    @(posedge CLK);
    #2;
    check_eq("write_oe", 32'(bus.BUS_DATA_OE), 32'd0);
    bus.BUS_WE   = 1'b0;
    bus.BUS_ADDR = 8'h00;

    // Basic packet
    base = rise_cnt; model_commit(8'h08, 8'h0A, 8'h05); send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);
    check_commit("basic", base, 1'b1); ack_irq("basic");

    // Clamp low, then clamp high twice
    base = rise_cnt; model_commit(8'h18, 8'h00, 8'h00); send_pkt(8'h18, 8'h00, 8'h00, 1'b0);
    check_commit("clamp_lo", base, 1'b1); ack_irq("clamp_lo");
    for (int k = 0; k < 2; k++) begin
      base = rise_cnt; model_commit(8'h08, 8'hFF, 8'h00); send_pkt(8'h08, 8'hFF, 8'h00, 1'b0);
      check_commit("clamp_hi", base, 1'b1); ack_irq("clamp_hi");
    end

    // X overflow: X held, Y moves
    base = rise_cnt; model_commit(8'h48, 8'h10, 8'h10); send_pkt(8'h48, 8'h10, 8'h10, 1'b0);
    check_commit("x_ovf", base, 1'b1); ack_irq("x_ovf");

    // Junk first byte is dropped, following packet commits once
    base = rise_cnt;
    ps2_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    model_commit(8'h18, 8'hF6, 8'h05); send_pkt(8'h18, 8'hF6, 8'h05, 1'b0);
    check_commit("resync", base, 1'b1); ack_irq("resync");

    // Timeout after byte 1 abandons the packet
    base = rise_cnt;
    ps2_byte(8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    ps2_byte(8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (TO + 100) @(negedge CLK);
    check_eq("timeout_no_commit", 32'(rise_cnt), 32'(base));
    model_commit(8'h28, 8'h03, 8'hFB); send_pkt(8'h28, 8'h03, 8'hFB, 1'b0);
    check_commit("timeout", base, 1'b1); ack_irq("timeout");

    // Bad stop bit discards the byte and restarts the packet
    base = rise_cnt;
    ps2_byte(8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    ps2_byte(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    model_commit(8'h08, 8'h01, 8'h01); send_pkt(8'h08, 8'h01, 8'h01, 1'b0);
    check_commit("bad_stop", base, 1'b1); ack_irq("bad_stop");

    // Wrong parity on byte 1
    base = rise_cnt;
`ifdef MOUSE_PARITY_CHECK_EN
    ps2_byte(8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    ps2_byte(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    model_commit(8'h08, 8'h02, 8'h02); send_pkt(8'h08, 8'h02, 8'h02, 1'b0);
`else
    model_commit(8'h08, 8'h02, 8'h02);
    ps2_byte(8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    ps2_byte(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    ps2_byte(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    check_commit("parity", base, 1'b1); ack_irq("parity");

    // Commit coinciding with ACK keeps the IRQ asserted
    base = rise_cnt; model_commit(8'h08, 8'h01, 8'h00); send_pkt(8'h08, 8'h01, 8'h00, 1'b0);
    check_commit("pre_same", base, 1'b1);
    base = rise_cnt; model_commit(8'h08, 8'h01, 8'h00); send_pkt(8'h08, 8'h01, 8'h00, 1'b1);
    check_commit("ack_same", base, 1'b0); ack_irq("ack_same");

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
